// File: rtl/rtoy_pkg.sv
// Shared RISC_TOY definitions: writeback-select encoding and the writeback bundle type.
package rtoy_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam int RTOY_DATA_W = 32;
  localparam int RTOY_WA_W   = 5;
  localparam int RTOY_SEL_W  = 2;

  typedef struct packed {
    logic                   valid;
    logic [RTOY_SEL_W-1:0]  sel;
    logic                   wen;
    logic [RTOY_DATA_W-1:0] aluout;
    logic [RTOY_DATA_W-1:0] pcadd4;
    logic [RTOY_WA_W-1:0]   wa;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_pipe_fwd_lookup.sv
// Forwarding lookup across all in-flight MEM stages for one read port; the
// youngest matching stage (lowest index) supplies the bypass value.
module fwd_lookup
  import rtoy_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WA_W   = 5,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 1
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0]             wen,
  input  logic [DEPTH-1:0][SEL_W-1:0]  sel,
  input  logic [DEPTH-1:0][DATA_W-1:0] aluout,
  input  logic [DEPTH-1:0][DATA_W-1:0] pcadd4,
  input  logic [DEPTH-1:0][WA_W-1:0]   wa,
  input  logic [WA_W-1:0]              ra,
  output logic                         hit,
  output logic                         pend,
  output logic [DATA_W-1:0]            data
);

  logic [DEPTH-1:0] match_s;

  // Per-stage match vector; register 0 never forwards.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_s[k] = valid[k] & wen[k] & (wa[k] == ra) & (ra != {WA_W{1'b0}});
    end
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    data = {DATA_W{1'b0}};
    pend = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      data = match_s[k] ? ((sel[k] == SEL_W'(WB_PC4)) ? pcadd4[k] : aluout[k]) : data;
      pend = match_s[k] ? (sel[k] == SEL_W'(WB_LOAD)) : pend;
    end
  end

  assign hit = |match_s;

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM1->MEM2 writeback pipeline of DEPTH stages with stall/flush/bubble handling.
// Optional register-forwarding lookup is built when MEMPIPE_FWD_EN is defined.
module mem_stage_pipe
  import rtoy_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WA_W   = 5,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              VALID_IN,
  input  logic [SEL_W-1:0]  SelWB_IN,
  input  logic              WEN_IN,
  input  logic [DATA_W-1:0] ALUOUT_IN,
  input  logic [DATA_W-1:0] PCADD4_IN,
  input  logic [WA_W-1:0]   WA_IN,
  output logic              VALID_OUT,
  output logic [SEL_W-1:0]  SelWB_OUT,
  output logic              WEN_OUT,
  output logic [DATA_W-1:0] ALUOUT_OUT,
  output logic [DATA_W-1:0] PCADD4_OUT,
  output logic [WA_W-1:0]   WA_OUT,
  input  logic [WA_W-1:0]   RA1,
  input  logic [WA_W-1:0]   RA2,
  output logic              FWD_HIT1,
  output logic              FWD_HIT2,
  output logic [DATA_W-1:0] FWD_DATA1,
  output logic [DATA_W-1:0] FWD_DATA2,
  output logic              FWD_PEND1,
  output logic              FWD_PEND2
);

  logic [DEPTH-1:0]             valid_r;
  logic [DEPTH-1:0]             wen_r;
  logic [DEPTH-1:0][SEL_W-1:0]  sel_r;
  logic [DEPTH-1:0][DATA_W-1:0] alu_r;
  logic [DEPTH-1:0][DATA_W-1:0] pc_r;
  logic [DEPTH-1:0][WA_W-1:0]   wa_r;

  logic             in_wen_s;
  logic [SEL_W-1:0] in_sel_s;

  // A bubble entering stage 0 carries neither a write nor a select.
  always_comb begin
    in_wen_s = WEN_IN & VALID_IN;
    if (VALID_IN) begin
      in_sel_s = SelWB_IN;
    end else begin
      in_sel_s = {SEL_W{1'b0}};
    end
  end

  // Stage registers: flush kills control bits only, stall holds, else shift.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_r <= '0;
      wen_r   <= '0;
      sel_r   <= '0;
      alu_r   <= '0;
      pc_r    <= '0;
      wa_r    <= '0;
    end else if (FLUSH) begin
      valid_r <= '0;
      wen_r   <= '0;
      sel_r   <= '0;
    end else if (!STALL) begin
      valid_r[0] <= VALID_IN;
      wen_r[0]   <= in_wen_s;
      sel_r[0]   <= in_sel_s;
      alu_r[0]   <= ALUOUT_IN;
      pc_r[0]    <= PCADD4_IN;
      wa_r[0]    <= WA_IN;
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
        wen_r[k]   <= wen_r[k-1];
        sel_r[k]   <= sel_r[k-1];
        alu_r[k]   <= alu_r[k-1];
        pc_r[k]    <= pc_r[k-1];
        wa_r[k]    <= wa_r[k-1];
      end
    end
  end

  assign VALID_OUT  = valid_r[DEPTH-1];
  assign SelWB_OUT  = sel_r[DEPTH-1];
  assign WEN_OUT    = wen_r[DEPTH-1];
  assign ALUOUT_OUT = alu_r[DEPTH-1];
  assign PCADD4_OUT = pc_r[DEPTH-1];
  assign WA_OUT     = wa_r[DEPTH-1];

`ifdef MEMPIPE_FWD_EN
  fwd_lookup #(
    .DATA_W(DATA_W), .WA_W(WA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)
  ) u_fwd1 (
    .valid(valid_r), .wen(wen_r), .sel(sel_r), .aluout(alu_r), .pcadd4(pc_r),
    .wa(wa_r), .ra(RA1), .hit(FWD_HIT1), .pend(FWD_PEND1), .data(FWD_DATA1)
  );

  fwd_lookup #(
    .DATA_W(DATA_W), .WA_W(WA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)
  ) u_fwd2 (
    .valid(valid_r), .wen(wen_r), .sel(sel_r), .aluout(alu_r), .pcadd4(pc_r),
    .wa(wa_r), .ra(RA2), .hit(FWD_HIT2), .pend(FWD_PEND2), .data(FWD_DATA2)
  );
`else
  logic unused_ra_s;
  assign unused_ra_s = ^{RA1, RA2};

  assign FWD_HIT1  = 1'b0;
  assign FWD_HIT2  = 1'b0;
  assign FWD_PEND1 = 1'b0;
  assign FWD_PEND2 = 1'b0;
  assign FWD_DATA1 = {DATA_W{1'b0}};
  assign FWD_DATA2 = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Randomized bench for mem_stage_pipe against a queue-based reference model,
// including async reset mid-stream and combined flush/stall cycles.
module tb_mem_stage_pipe;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int SW    = 2;
  localparam int DEPTH = 3;
`ifdef MEMPIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          STALL, FLUSH, VALID_IN, WEN_IN;
  logic [SW-1:0] SelWB_IN;
  logic [DW-1:0] ALUOUT_IN, PCADD4_IN;
  logic [AW-1:0] WA_IN, RA1, RA2;
  logic          VALID_OUT, WEN_OUT;
  logic [SW-1:0] SelWB_OUT;
  logic [DW-1:0] ALUOUT_OUT, PCADD4_OUT;
  logic [AW-1:0] WA_OUT;
  logic          FWD_HIT1, FWD_HIT2, FWD_PEND1, FWD_PEND2;
  logic [DW-1:0] FWD_DATA1, FWD_DATA2;

  always #5 CLK = ~CLK;

  mem_stage_pipe #(.DATA_W(DW), .WA_W(AW), .SEL_W(SW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .FLUSH(FLUSH), .VALID_IN(VALID_IN),
    .SelWB_IN(SelWB_IN), .WEN_IN(WEN_IN), .ALUOUT_IN(ALUOUT_IN), .PCADD4_IN(PCADD4_IN),
    .WA_IN(WA_IN), .VALID_OUT(VALID_OUT), .SelWB_OUT(SelWB_OUT), .WEN_OUT(WEN_OUT),
    .ALUOUT_OUT(ALUOUT_OUT), .PCADD4_OUT(PCADD4_OUT), .WA_OUT(WA_OUT),
    .RA1(RA1), .RA2(RA2), .FWD_HIT1(FWD_HIT1), .FWD_HIT2(FWD_HIT2),
    .FWD_DATA1(FWD_DATA1), .FWD_DATA2(FWD_DATA2),
    .FWD_PEND1(FWD_PEND1), .FWD_PEND2(FWD_PEND2)
  );

  typedef struct {
    logic          v;
    logic [SW-1:0] sel;
    logic          wen;
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [AW-1:0] wa;
  } ent_t;

  // Model: queue of in-flight entries, index 0 youngest, back is the output stage.
  ent_t mdl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '{v: 1'b0, sel: '0, wen: 1'b0, alu: '0, pc: '0, wa: '0};
    mdl.delete();
    for (int i = 0; i < DEPTH; i++) mdl.push_back(z);
  endtask

  task automatic model_edge();
    ent_t e;
    if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdl[i].v = 1'b0; mdl[i].wen = 1'b0; mdl[i].sel = '0;
      end
    end else if (!STALL) begin
      e.v   = VALID_IN;
      e.sel = VALID_IN ? SelWB_IN : '0;
      e.wen = VALID_IN && WEN_IN;
      e.alu = ALUOUT_IN;
      e.pc  = PCADD4_IN;
      e.wa  = WA_IN;
      mdl.push_front(e);
      void'(mdl.pop_back());
    end
  endtask

  task automatic exp_fwd(input logic [AW-1:0] ra, output logic hit, output logic pend,
                         output logic [DW-1:0] data);
    hit = 1'b0; pend = 1'b0; data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && mdl[k].v && mdl[k].wen && mdl[k].wa == ra && ra != 0) begin
        hit  = 1'b1;
        pend = (mdl[k].sel == 2'd1);
        data = (mdl[k].sel == 2'd2) ? mdl[k].pc : mdl[k].alu;
      end
    end
    if (!FWD_ON) begin
      hit = 1'b0; pend = 1'b0; data = '0;
    end
  endtask

  task automatic check_all();
    ent_t          o;
    logic          h, p;
    logic [DW-1:0] d;
    o = mdl[DEPTH-1];
    check_eq("valid_out", 64'(VALID_OUT), 64'(o.v));
    check_eq("selwb_out", 64'(SelWB_OUT), 64'(o.sel));
    check_eq("wen_out", 64'(WEN_OUT), 64'(o.wen));
    check_eq("aluout_out", 64'(ALUOUT_OUT), 64'(o.alu));
    check_eq("pcadd4_out", 64'(PCADD4_OUT), 64'(o.pc));
    check_eq("wa_out", 64'(WA_OUT), 64'(o.wa));
    check_eq("wen_without_valid", 64'(WEN_OUT & ~VALID_OUT), 64'd0);
    exp_fwd(RA1, h, p, d);
    check_eq("fwd_hit1", 64'(FWD_HIT1), 64'(h));
    check_eq("fwd_pend1", 64'(FWD_PEND1), 64'(p));
    check_eq("fwd_data1", 64'(FWD_DATA1), 64'(d));
    exp_fwd(RA2, h, p, d);
    check_eq("fwd_hit2", 64'(FWD_HIT2), 64'(h));
    check_eq("fwd_pend2", 64'(FWD_PEND2), 64'(p));
    check_eq("fwd_data2", 64'(FWD_DATA2), 64'(d));
  endtask

  initial begin
    RSTN = 1'b0; STALL = 1'b0; FLUSH = 1'b0; VALID_IN = 1'b0; WEN_IN = 1'b0;
    SelWB_IN = '0; ALUOUT_IN = '0; PCADD4_IN = '0; WA_IN = '0; RA1 = '0; RA2 = '0;
    model_reset();
    #2;
    check_all();
    #10 RSTN = 1'b1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      FLUSH     = ($urandom_range(0, 19) == 0);
      STALL     = FLUSH ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
      VALID_IN  = ($urandom_range(0, 3) != 0);
      WEN_IN    = ($urandom_range(0, 3) != 0);
      SelWB_IN  = SW'($urandom_range(0, 3));
      ALUOUT_IN = $urandom;
      PCADD4_IN = $urandom;
      WA_IN     = AW'($urandom_range(0, 3));
      RA1       = AW'($urandom_range(0, 3));
      RA2       = AW'($urandom_range(0, 3));
      if (cyc % 97 == 50) begin
        #2 RSTN = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 RSTN = 1'b1;
      end
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

- Parametrised replacement for the fixed single-register MEM1→MEM2 pipeline latch in the RISC_TOY core.
- Carries the writeback bundle (SelWB, WEN, ALUOUT, PCADD4, WA) through DEPTH register stages, with a valid bit, stall, flush and bubble injection per stage.
- Optionally exposes a two-port register-forwarding lookup over all in-flight stages for the hazard/bypass unit.
- Sits between the MEM1 stage output and the writeback mux.

## Interface
Parameters:
- DATA_W, 32, width of ALUOUT and PCADD4
- WA_W, 5, register address width
- SEL_W, 2, SelWB width
- DEPTH, 1, number of register stages, legal 1..4

Ports:
- Clocking: clock CLK; reset RSTN, asynchronous, active-low.
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- STALL  in  1  hold all stages
- FLUSH  in  1  kill all in-flight entries; overrides STALL
- VALID_IN  in  1  input bundle is a real instruction
- SelWB_IN  in  SEL_W  writeback select (0 ALU, 1 load, 2 PC+4, 3 ALU)
- WEN_IN  in  1  register write enable
- ALUOUT_IN, PCADD4_IN  in  DATA_W  data fields
- WA_IN  in  WA_W  destination register
- VALID_OUT, SelWB_OUT, WEN_OUT, ALUOUT_OUT, PCADD4_OUT, WA_OUT  out  as above  last-stage bundle
- RA1, RA2  in  WA_W  forwarding query addresses
- FWD_HIT1, FWD_HIT2  out  1  youngest matching stage found
- FWD_DATA1, FWD_DATA2  out  DATA_W  forwarded value
- FWD_PEND1, FWD_PEND2  out  1  match is a load; data not yet available

## Operation
- Stage k (0 = youngest) holds {valid, SelWB, WEN, ALUOUT, PCADD4, WA}.
- Outputs are driven by stage DEPTH-1.
- Priority per edge: FLUSH > STALL > advance.
- FLUSH: every stage's valid, WEN and SelWB are cleared to 0. Data and WA fields hold.
- STALL (FLUSH low): all stages hold every field.
- Advance:
  - Stage k takes stage k-1; stage 0 takes the inputs.
  - Stored WEN = WEN_IN & VALID_IN, so a bubble never writes.
  - When VALID_IN=0, SelWB is stored as 0 and the data fields are still captured.
- WEN_OUT is never 1 while VALID_OUT is 0.
- Forwarding lookup (per port p):
  - Match in stage k: valid_k & WEN_k & (WA_k == RAp) & (RAp != 0).
  - Purely combinational from the current stage contents. STALL and FLUSH inputs do not affect it.
  - The lowest-numbered (youngest) matching stage wins.
  - FWD_HITp = any match.
  - FWD_DATAp = PCADD4 of the winner if its SelWB=2, otherwise ALUOUT of the winner.
  - FWD_PENDp = winner's SelWB == 1.
  - No match: HIT=0, PEND=0, DATA=0.

## Timing
- Reset: every stage field is 0, so all *_OUT and FWD_* outputs are 0 during and after reset.
- Latency: an input accepted at edge n appears on *_OUT after edge n+DEPTH-1, i.e. DEPTH cycles later with no stalls. DEPTH=1 is cycle-equivalent to the legacy latch.
- A stalled cycle adds exactly one cycle to the latency of every in-flight entry. No entry is lost or duplicated.
- FLUSH and STALL in the same cycle: flush wins, stages are invalidated.
- RSTN assertion mid-stream clears all stages immediately, without waiting for CLK.
- Forwarding outputs reflect state after the most recent edge, with zero added latency.

## Configuration
- Macro: MEMPIPE_FWD_EN.
- Defined: the lookup logic and the RA1/RA2 and FWD_* ports are active as described above.
- Undefined: the lookup logic is not built. FWD_HITx, FWD_PENDx and FWD_DATAx are tied to 0. RA1/RA2 are ignored. The port list is unchanged.

## Structure
- Shared package (rtoy_pkg):
  - SelWB encoding constants: WB_ALU=0, WB_LOAD=1, WB_PC4=2.
  - A packed struct type for the writeback bundle {valid, sel, wen, aluout, pcadd4, wa}.
- Sub-module fwd_lookup:
  - Parametrised by DEPTH.
  - Takes the stage array and one RA.
  - Returns {hit, pend, data}.
  - Instantiated twice, inside the MEMPIPE_FWD_EN guard.

## Test plan
1. DEPTH=2, reset, then VALID_IN=1, WEN_IN=1, WA_IN=5, ALUOUT_IN=0x1234 for one cycle → VALID_OUT=1, WA_OUT=5, ALUOUT_OUT=0x1234 exactly 2 cycles later; all outputs 0 before that.
2. DEPTH=3, stream 3 entries, STALL high 2 cycles mid-stream → the outputs show the same 3 entries in order, each delayed by 2 cycles.
3. FLUSH with STALL both high while 2 entries are in flight → next cycle all valid=0 and WEN_OUT=0; later inputs flow normally.
4. VALID_IN=0 with WEN_IN=1 → WEN_OUT=0 and SelWB_OUT=0 when the bubble reaches the output.
5. MEMPIPE_FWD_EN, DEPTH=2:
   - Stage0 holds {WA=7, SelWB=2, PCADD4=0x40}; stage1 holds {WA=7, SelWB=0, ALUOUT=0x99}.
   - RA1=7 → HIT1=1, DATA1=0x40, PEND1=0.
   - RA1=0 → HIT1=0.
   - Stage0 SelWB=1 → PEND1=1.
6. RSTN pulsed low asynchronously between clock edges with 2 valid entries → all outputs 0 immediately; recovery after release.
